// File: rtl/legv8_pkg.sv
// Shared definitions for the LEGv8 control path: opcode patterns, the
// multi-cycle state encoding and the instruction class encoding.
package legv8_pkg;

  // Exact-match opcodes (instr[31:21])
  localparam logic [10:0] OP_LDUR   = 11'b11111000010;
  localparam logic [10:0] OP_STUR   = 11'b11111000000;
  localparam logic [10:0] OP_ADD    = 11'b10001011000;
  localparam logic [10:0] OP_SUB    = 11'b11001011000;
  localparam logic [10:0] OP_AND    = 11'b10001010000;
  localparam logic [10:0] OP_ORR    = 11'b10101010000;

  // Wildcard opcodes: the low bits belong to the immediate field
  localparam logic [10:0] OP_CBZ    = 11'b10110100000;
  localparam logic [10:0] MASK_CBZ  = 11'b11111111000;
  localparam logic [10:0] OP_B      = 11'b00010100000;
  localparam logic [10:0] MASK_B    = 11'b11111100000;
  localparam logic [10:0] MASK_FULL = 11'b11111111111;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CLS_R    = 3'd0,
    CLS_LDUR = 3'd1,
    CLS_STUR = 3'd2,
    CLS_CBZ  = 3'd3,
    CLS_B    = 3'd4,
    CLS_ILL  = 3'd5
  } class_t;

  // True when op equals pat on every bit selected by mask
  function automatic logic op_match(input logic [10:0] op,
                                    input logic [10:0] pat,
                                    input logic [10:0] mask);
    return (((op ^ pat) & mask) == 11'd0);
  endfunction

endpackage

// File: rtl/legv8_multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle. The controller is the slave side:
// it consumes opcode/flags/memory strobe and drives the control lines.
interface legv8_multicycle_ctrl_if;
  logic [10:0] opcode;
  logic        zero;
  logic        mem_ready;
  logic        ir_write;
  logic        pc_write;
  logic        pc_write_cond;
  logic [1:0]  pc_src;
  logic        alu_src_b;
  logic [1:0]  alu_op;
  logic        reg2loc;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        mem_to_reg;
  logic        retire;
  logic        illegal;
  logic [2:0]  state;

  modport master (
    output opcode, zero, mem_ready,
    input  ir_write, pc_write, pc_write_cond, pc_src, alu_src_b, alu_op,
           reg2loc, mem_read, mem_write, reg_write, mem_to_reg, retire,
           illegal, state
  );

  modport slave (
    input  opcode, zero, mem_ready,
    output ir_write, pc_write, pc_write_cond, pc_src, alu_src_b, alu_op,
           reg2loc, mem_read, mem_write, reg_write, mem_to_reg, retire,
           illegal, state
  );
endinterface

// File: rtl/legv8_opclass_decode.sv
// Combinational opcode -> instruction class decoder, shared with the
// single-cycle control.
module legv8_opclass_decode
  import legv8_pkg::*;
(
  input  logic [10:0] opcode_i,
  output class_t      op_class_o
);

  // Classify the opcode; anything unrecognised is illegal
  always_comb begin
    op_class_o = CLS_ILL;
    if (op_match(opcode_i, OP_LDUR, MASK_FULL)) begin
      op_class_o = CLS_LDUR;
    end else if (op_match(opcode_i, OP_STUR, MASK_FULL)) begin
      op_class_o = CLS_STUR;
    end else if (op_match(opcode_i, OP_ADD, MASK_FULL) ||
                 op_match(opcode_i, OP_SUB, MASK_FULL) ||
                 op_match(opcode_i, OP_AND, MASK_FULL) ||
                 op_match(opcode_i, OP_ORR, MASK_FULL)) begin
      op_class_o = CLS_R;
    end else if (op_match(opcode_i, OP_CBZ, MASK_CBZ)) begin
      op_class_o = CLS_CBZ;
    end else if (op_match(opcode_i, OP_B, MASK_B)) begin
      op_class_o = CLS_B;
    end else begin
      op_class_o = CLS_ILL;
    end
  end

endmodule

// File: rtl/legv8_multicycle_ctrl.sv
// Multi-cycle Moore sequencer for the LEGv8 datapath. Holds the state,
// latched instruction class and sticky illegal flag; control lines are
// decoded from those plus mem_ready and are held low while rst_n is low.
module legv8_multicycle_ctrl
  import legv8_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  legv8_multicycle_ctrl_if.slave  bus
);

  state_t state_q, state_d;
  class_t class_q, class_d;
  logic   illegal_q, illegal_d;
  class_t dec_class_s;

  // The zero flag gates the PC through pc_write_cond in the datapath;
  // the sequence of control lines does not depend on it.
  logic   unused_zero_s;
  assign unused_zero_s = bus.zero;

  legv8_opclass_decode u_decode (
    .opcode_i   (bus.opcode),
    .op_class_o (dec_class_s)
  );

  // Next-state, class latch and sticky illegal computation
  always_comb begin
    state_d   = state_q;
    class_d   = class_q;
    illegal_d = illegal_q;
    case (state_q)
      FETCH: begin
        if (bus.mem_ready) begin
          state_d = DECODE;
        end else begin
          state_d = FETCH;
        end
      end
      DECODE: begin
        class_d = dec_class_s;
        if (dec_class_s == CLS_ILL) begin
          state_d   = HALT;
          illegal_d = 1'b1;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        case (class_q)
          CLS_R:    state_d = WB;
          CLS_LDUR: state_d = MEM;
          CLS_STUR: state_d = MEM;
          CLS_CBZ:  state_d = FETCH;
          CLS_B:    state_d = FETCH;
          default:  state_d = HALT;
        endcase
      end
      MEM: begin
        if (!bus.mem_ready) begin
          state_d = MEM;
        end else if (class_q == CLS_STUR) begin
          state_d = FETCH;
        end else begin
          state_d = WB;
        end
      end
      WB:      state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // Sequencer registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      class_q   <= CLS_R;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      illegal_q <= illegal_d;
    end
  end

  // Moore output decode; every line forced low while reset is asserted
  always_comb begin
    bus.ir_write      = 1'b0;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.pc_src        = 2'b00;
    bus.alu_src_b     = 1'b0;
    bus.alu_op        = 2'b00;
    bus.reg2loc       = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.reg_write     = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.retire        = 1'b0;
    bus.illegal       = 1'b0;
    bus.state         = 3'd0;
    if (!rst_n) begin
      bus.state = 3'd0;
    end else begin
      bus.state   = state_q;
      bus.illegal = illegal_q;
      case (state_q)
        FETCH: begin
          bus.mem_read = 1'b1;
          if (bus.mem_ready) begin
            bus.ir_write = 1'b1;
            bus.pc_write = 1'b1;
            bus.pc_src   = 2'b00;
          end else begin
            bus.ir_write = 1'b0;
          end
        end
        DECODE: begin
          // Rt must already be on read port 2 when EXEC/MEM use it
          bus.reg2loc = (dec_class_s == CLS_STUR) || (dec_class_s == CLS_CBZ);
        end
        EXEC: begin
          case (class_q)
            CLS_R: begin
              bus.alu_src_b = 1'b0;
              bus.alu_op    = 2'b10;
            end
            CLS_LDUR, CLS_STUR: begin
              bus.alu_src_b = 1'b1;
              bus.alu_op    = 2'b00;
            end
            CLS_CBZ: begin
              bus.reg2loc       = 1'b1;
              bus.alu_op        = 2'b01;
              bus.pc_write_cond = 1'b1;
              bus.pc_src        = 2'b01;
              bus.retire        = 1'b1;
            end
            CLS_B: begin
              bus.pc_write = 1'b1;
              bus.pc_src   = 2'b10;
              bus.retire   = 1'b1;
            end
            default: begin
              bus.retire = 1'b0;
            end
          endcase
        end
        MEM: begin
          // Address stays stable on the ALU for the whole memory wait
          bus.alu_src_b = 1'b1;
          bus.alu_op    = 2'b00;
          if (class_q == CLS_STUR) begin
            bus.mem_write = 1'b1;
            bus.reg2loc   = 1'b1;
            bus.retire    = bus.mem_ready;
          end else begin
            bus.mem_read = 1'b1;
          end
        end
        WB: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = (class_q == CLS_LDUR);
          bus.retire     = 1'b1;
        end
        HALT: begin
          bus.retire = 1'b0;
        end
        default: begin
          bus.retire = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Directed bench for the LEGv8 multi-cycle controller: walks each
// instruction class cycle by cycle against hand-computed control words.
module tb_legv8_multicycle_ctrl;
  import legv8_pkg::*;

  // Control word bit positions (expected values are ORs of these)
  localparam logic [15:0] C_IRW  = 16'h8000;
  localparam logic [15:0] C_PCW  = 16'h4000;
  localparam logic [15:0] C_PCC  = 16'h2000;
  localparam logic [15:0] C_SRC2 = 16'h1000;  // pc_src = 10
  localparam logic [15:0] C_SRC1 = 16'h0800;  // pc_src = 01
  localparam logic [15:0] C_ALUB = 16'h0400;
  localparam logic [15:0] C_OP2  = 16'h0200;  // alu_op = 10
  localparam logic [15:0] C_OP1  = 16'h0100;  // alu_op = 01
  localparam logic [15:0] C_R2L  = 16'h0080;
  localparam logic [15:0] C_MR   = 16'h0040;
  localparam logic [15:0] C_MW   = 16'h0020;
  localparam logic [15:0] C_RW   = 16'h0010;
  localparam logic [15:0] C_M2R  = 16'h0008;
  localparam logic [15:0] C_RET  = 16'h0004;
  localparam logic [15:0] C_ILL  = 16'h0002;
  localparam logic [15:0] C_NONE = 16'h0000;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  logic [15:0] obs_c;

  legv8_multicycle_ctrl_if bus ();

  legv8_multicycle_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs_c = {bus.ir_write, bus.pc_write, bus.pc_write_cond, bus.pc_src,
                  bus.alu_src_b, bus.alu_op, bus.reg2loc, bus.mem_read,
                  bus.mem_write, bus.reg_write, bus.mem_to_reg, bus.retire,
                  bus.illegal, 1'b0};

  // Check one cycle at the falling edge, then advance past the rising edge
  task automatic step(input string tag, input logic [2:0] exp_st,
                      input logic [15:0] exp_c);
    @(negedge clk);
    tests++;
    assert (bus.state === exp_st) else begin
      fails++;
      $error("FAIL %s state obs=%0d exp=%0d", tag, bus.state, exp_st);
    end
    tests++;
    assert (obs_c === exp_c) else begin
      fails++;
      $error("FAIL %s ctrl obs=%h exp=%h", tag, obs_c, exp_c);
    end
    tests++;
    assert (!(bus.mem_read && bus.mem_write) && !(bus.pc_write && bus.pc_write_cond)) else begin
      fails++;
      $error("FAIL %s exclusive obs=%b%b%b%b exp=no-overlap", tag,
             bus.mem_read, bus.mem_write, bus.pc_write, bus.pc_write_cond);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.opcode    = 11'd0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;

    // Reset: everything low, state FETCH
    step("reset", 3'd0, C_NONE);
    rst_n = 1'b1;

    // LDUR, no stalls: 5 cycles
    bus.opcode = 11'b11111000010;
    step("ldur_fetch",  3'd0, C_MR | C_IRW | C_PCW);
    step("ldur_decode", 3'd1, C_NONE);
    step("ldur_exec",   3'd2, C_ALUB);
    step("ldur_mem",    3'd3, C_ALUB | C_MR);
    step("ldur_wb",     3'd4, C_RW | C_M2R | C_RET);

    // STUR with 3 wait cycles in MEM; opcode changes after DECODE
    bus.opcode = 11'b11111000000;
    step("stur_fetch",  3'd0, C_MR | C_IRW | C_PCW);
    step("stur_decode", 3'd1, C_R2L);
    bus.opcode = 11'b10001011000;
    step("stur_exec",   3'd2, C_ALUB);
    bus.mem_ready = 1'b0;
    step("stur_wait1",  3'd3, C_ALUB | C_MW | C_R2L);
    step("stur_wait2",  3'd3, C_ALUB | C_MW | C_R2L);
    step("stur_wait3",  3'd3, C_ALUB | C_MW | C_R2L);
    bus.mem_ready = 1'b1;
    step("stur_mem",    3'd3, C_ALUB | C_MW | C_R2L | C_RET);

    // ADD: 4 cycles
    bus.opcode = 11'b10001011000;
    step("add_fetch",  3'd0, C_MR | C_IRW | C_PCW);
    step("add_decode", 3'd1, C_NONE);
    step("add_exec",   3'd2, C_OP2);
    step("add_wb",     3'd4, C_RW | C_RET);

    // SUB with one FETCH stall first
    bus.opcode = 11'b11001011000;
    bus.mem_ready = 1'b0;
    step("sub_fstall", 3'd0, C_MR);
    bus.mem_ready = 1'b1;
    step("sub_fetch",  3'd0, C_MR | C_IRW | C_PCW);
    step("sub_decode", 3'd1, C_NONE);
    step("sub_exec",   3'd2, C_OP2);
    step("sub_wb",     3'd4, C_RW | C_RET);

    // CBZ taken (zero=1)
    bus.opcode = 11'b10110100101;
    bus.zero   = 1'b1;
    step("cbz1_fetch",  3'd0, C_MR | C_IRW | C_PCW);
    step("cbz1_decode", 3'd1, C_R2L);
    step("cbz1_exec",   3'd2, C_R2L | C_OP1 | C_PCC | C_SRC1 | C_RET);

    // CBZ not taken (zero=0): identical control, still 3 cycles
    bus.zero = 1'b0;
    step("cbz0_fetch",  3'd0, C_MR | C_IRW | C_PCW);
    step("cbz0_decode", 3'd1, C_R2L);
    step("cbz0_exec",   3'd2, C_R2L | C_OP1 | C_PCC | C_SRC1 | C_RET);

    // B: 3 cycles
    bus.opcode = 11'b00010100000;
    step("b_fetch",  3'd0, C_MR | C_IRW | C_PCW);
    step("b_decode", 3'd1, C_NONE);
    step("b_exec",   3'd2, C_PCW | C_SRC2 | C_RET);

    // Reset during the 2nd MEM wait of an LDUR
    bus.opcode = 11'b11111000010;
    step("rl_fetch",  3'd0, C_MR | C_IRW | C_PCW);
    step("rl_decode", 3'd1, C_NONE);
    step("rl_exec",   3'd2, C_ALUB);
    bus.mem_ready = 1'b0;
    step("rl_wait1",  3'd3, C_ALUB | C_MR);
    rst_n = 1'b0;
    step("rl_wait2_rst", 3'd0, C_NONE);
    rst_n = 1'b1;
    step("rl_after", 3'd0, C_MR);
    bus.mem_ready = 1'b1;
    step("rl_refetch", 3'd0, C_MR | C_IRW | C_PCW);
    step("rl_redecode", 3'd1, C_NONE);
    step("rl_reexec",   3'd2, C_ALUB);
    step("rl_remem",    3'd3, C_ALUB | C_MR);
    step("rl_rewb",     3'd4, C_RW | C_M2R | C_RET);

    // Illegal opcode: DECODE then HALT forever, mem_ready ignored
    bus.opcode = 11'b11111111111;
    step("ill_fetch",  3'd0, C_MR | C_IRW | C_PCW);
    step("ill_decode", 3'd1, C_NONE);
    bus.opcode = 11'b10001011000;
    for (int i = 0; i < 10; i++) begin
      bus.mem_ready = i[0];
      step($sformatf("halt_%0d", i), 3'd5, C_ILL);
    end
    bus.mem_ready = 1'b1;
    rst_n = 1'b0;
    step("halt_rst", 3'd0, C_NONE);
    rst_n = 1'b1;
    step("halt_exit_fetch", 3'd0, C_MR | C_IRW | C_PCW);
    step("halt_exit_decode", 3'd1, C_NONE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/legv8_multicycle_ctrl.md
# legv8_multicycle_ctrl

Multi-cycle sequencing controller for the LEGv8 datapath. It replaces single-cycle opcode decode with a Moore state machine. The machine steps each instruction through fetch, decode, execute, memory and writeback, and drives the datapath mux selects and write enables state by state. Memory accesses use a ready handshake so one shared instruction/data memory can stall the core.

## Interface
Parameters: none. Opcode constants, state and class encodings come from the shared package.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low; sampled on rising clk
- opcode  in  11  instr[31:21] from the datapath instruction register; valid from DECODE onward
- zero  in  1  ALU zero flag; sampled in EXEC
- mem_ready  in  1  memory completion strobe for the current read/write
- ir_write  out  1  load the instruction register
- pc_write  out  1  unconditional PC update
- pc_write_cond  out  1  PC update if zero=1
- pc_src  out  2  00 PC+4, 01 CBZ target, 10 B target
- alu_src_b  out  1  0 register, 1 sign-extended immediate
- alu_op  out  2  00 add (address), 01 pass-B (CBZ), 10 funct decode (R)
- reg2loc  out  1  1 selects Rt as read register 2 (STUR, CBZ)
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- reg_write  out  1  register file write enable
- mem_to_reg  out  1  1 writes back memory data, 0 writes back ALU result
- retire  out  1  one-cycle pulse as each instruction completes
- illegal  out  1  sticky flag for an undecodable opcode
- state  out  3  current state, for debug and verification

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- Instruction classes are latched in DECODE into a class register:
  - LDUR 11111000010
  - STUR 11111000000
  - R: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000
  - CBZ 10110100xxx
  - B 000101xxxxx
  - anything else is ILL
- FETCH: mem_read=1.
  - mem_ready=0: stay in FETCH.
  - mem_ready=1: ir_write=1, pc_write=1, pc_src=00 in the same cycle, then go to DECODE.
- DECODE: reg2loc=1 if the opcode is STUR or CBZ.
  - ILL: go to HALT.
  - Any other class: go to EXEC.
- EXEC, by latched class:
  - R: alu_src_b=0, alu_op=10, then WB.
  - LDUR/STUR: alu_src_b=1, alu_op=00, then MEM.
  - CBZ: reg2loc=1, alu_op=01, pc_write_cond=1, pc_src=01, retire=1, then FETCH.
  - B: pc_write=1, pc_src=10, retire=1, then FETCH.
- MEM: alu_src_b=1 and alu_op=00 stay held.
  - LDUR: mem_read=1.
  - STUR: mem_write=1, reg2loc=1.
  - mem_ready=0: stay in MEM.
  - mem_ready=1: LDUR goes to WB; STUR asserts retire=1 and goes to FETCH.
- WB: reg_write=1, mem_to_reg=1 for LDUR and 0 for R, retire=1, then FETCH.
- HALT: all enables 0 and illegal=1. Only reset leaves HALT.
- mem_read and mem_write are never asserted in the same cycle.
- No more than one of pc_write and pc_write_cond is asserted in any cycle.

## Timing
- Reset: while rst_n=0 at a clk edge, the next state is FETCH, the class register clears and illegal clears.
  - While rst_n is low, all outputs are forced 0 combinationally.
  - state reads FETCH after that edge.
- Outputs are combinational from state, class and mem_ready; there are no registered outputs besides state, class and illegal.
- Cycles per instruction with mem_ready tied to 1:
  - LDUR 5
  - STUR 4
  - R 4
  - CBZ 3
  - B 3
- Each cycle with mem_ready=0 in FETCH or MEM adds one cycle.
- mem_ready is ignored outside FETCH and MEM.
- Reset mid-operation, including during a MEM wait, aborts with no retire. The next cycle is FETCH with all enables 0 while rst_n is low.
- opcode may change after DECODE; execution follows the latched class.

## Structure
- Shared package legv8_pkg holds:
  - opcode constants and wildcard masks
  - state_t enum (3 bits): FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5
  - class_t enum: R, LDUR, STUR, CBZ, B, ILL
- Sub-module legv8_opclass_decode: combinational opcode → class_t decoder, reused by the single-cycle control.
- The top level holds the state and class registers, next-state logic and output decode.

## Test plan
- LDUR 11111000010, mem_ready=1 → states FETCH, DECODE, EXEC, MEM, WB.
  - mem_read=1 in FETCH and MEM.
  - WB: reg_write=1, mem_to_reg=1.
  - retire=1 only in cycle 5.
- STUR 11111000000, mem_ready low for 3 cycles in MEM → MEM held 4 cycles with mem_write=1 and reg2loc=1; retire on the 4th; reg_write never 1.
- ADD 10001011000, then SUB 11001011000 → each takes 4 cycles; EXEC alu_op=10 and alu_src_b=0; WB reg_write=1 and mem_to_reg=0.
- CBZ 10110100101:
  - zero=1 → EXEC pc_write_cond=1, pc_src=01, back to FETCH.
  - zero=0 → same outputs, 3-cycle total.
  - B 00010100000 → pc_write=1, pc_src=10.
- Opcode 11111111111 → DECODE then HALT. illegal=1 and every enable is 0 for 10 cycles. A reset pulse returns to FETCH with illegal=0.
- rst_n=0 during the 2nd MEM wait cycle of an LDUR → all outputs 0 that cycle, FETCH next, no retire, no reg_write.
